// File: rtl/agu_pkg.sv
// Shared types and helpers for the load/store AGU: access sizes, shadow entries,
// byte-enable generation and alignment checks. Pure combinational helpers, no state.
package agu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } acc_size_e;

  // Register index field is sized for the widest supported GPR index; narrower indices are zero-extended.
  localparam int GPR_AW_MAX = 8;

  typedef struct packed {
    logic                  valid;
    logic [GPR_AW_MAX-1:0] rd;
    logic                  is_load;
  } shadow_ent_t;

  function automatic logic [7:0] be_gen(acc_size_e size, logic [2:0] offset);
    logic [7:0] be;
    case (size)
      SZ_B:    be = 8'h01 << offset;
      SZ_H:    be = 8'h03 << offset;
      SZ_W:    be = 8'h0F << offset;
      default: be = 8'hFF;
    endcase
    return be;
  endfunction

  function automatic logic is_aligned(acc_size_e size, logic [2:0] addr_lsbs);
    logic ok;
    case (size)
      SZ_B:    ok = 1'b1;
      SZ_H:    ok = (addr_lsbs[0] == 1'b0);
      SZ_W:    ok = (addr_lsbs[1:0] == 2'b00);
      default: ok = (addr_lsbs == 3'b000);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/agu_fwd_unit.sv
// Shadow of in-flight register writers with lowest-stage-wins operand forwarding; operand is 0-cycle.
// Shadow keeps shifting under stall so writebacks drain; load_use_hazard tells the top to hold EX.
module agu_fwd_unit
  import agu_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int GPR_ADDR_WIDTH = 5,
  parameter int FWD_DEPTH      = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            advance,
  input  logic                            in_valid,
  input  logic                            in_mem_op,
  input  logic                            in_is_load,
  input  logic [GPR_ADDR_WIDTH-1:0]       in_rd,
  input  logic                            in_reg_wr_en,
  input  logic [GPR_ADDR_WIDTH-1:0]       rs1_addr,
  input  logic [DATA_WIDTH-1:0]           rs1_data,
  input  logic [FWD_DEPTH*DATA_WIDTH-1:0] fwd_data,
  output logic [DATA_WIDTH-1:0]           operand,
  output logic                            load_use_hazard
);

  shadow_ent_t           shadow_q [FWD_DEPTH];
  logic [FWD_DEPTH-1:0]  match;
  logic [GPR_AW_MAX-1:0] rs1_ext;

  assign rs1_ext = GPR_AW_MAX'(rs1_addr);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < FWD_DEPTH; k++) shadow_q[k] <= '0;
    end else begin
      // A held EX instruction is not recorded yet; a bubble enters instead.
      if (advance)
        shadow_q[0] <= '{valid: in_valid & in_reg_wr_en, rd: GPR_AW_MAX'(in_rd), is_load: in_is_load};
      else
        shadow_q[0] <= '0;
      for (int k = 1; k < FWD_DEPTH; k++) shadow_q[k] <= shadow_q[k-1];
    end
  end

  always_comb begin
    match = '0;
    for (int k = 0; k < FWD_DEPTH; k++)
      match[k] = shadow_q[k].valid && (shadow_q[k].rd != '0) && (shadow_q[k].rd == rs1_ext);
  end

  always_comb begin
    operand = rs1_data;
    // Walk from oldest to youngest so the youngest producer overrides.
    for (int k = FWD_DEPTH - 1; k >= 0; k--)
      if (match[k]) operand = fwd_data[k*DATA_WIDTH +: DATA_WIDTH];
  end

  assign load_use_hazard = in_valid & in_mem_op & match[0] & shadow_q[0].is_load;

endmodule

// File: rtl/ld_st_agu_v2.sv
// Load/store AGU: forwarded rs1 + imm, legality check, byte enables; request is 1 cycle after accept.
// One-entry registered valid/ready slot; a held request (req_valid & !req_ready) blocks new accepts.
module ld_st_agu_v2
  import agu_pkg::*;
#(
  parameter  int DATA_WIDTH     = 32,
  parameter  int GPR_ADDR_WIDTH = 5,
  parameter  int FWD_DEPTH      = 3,
  localparam int BE_WIDTH       = DATA_WIDTH / 8
) (
  input  logic                            agu_clk,
  input  logic                            agu_rst,
  input  logic                            in_valid,
  input  logic                            in_is_load,
  input  logic                            in_is_store,
  input  logic [1:0]                      in_size,
  input  logic                            in_unsigned,
  input  logic [GPR_ADDR_WIDTH-1:0]       in_rd,
  input  logic                            in_reg_wr_en,
  input  logic [GPR_ADDR_WIDTH-1:0]       rs1_addr,
  input  logic [DATA_WIDTH-1:0]           rs1_data,
  input  logic [DATA_WIDTH-1:0]           imm_val,
  input  logic [FWD_DEPTH*DATA_WIDTH-1:0] fwd_data,
  input  logic                            stall_pipeline,
  output logic                            req_valid,
  input  logic                            req_ready,
  output logic [DATA_WIDTH-1:0]           req_addr,
  output logic                            req_we,
  output logic [BE_WIDTH-1:0]             req_be,
  output logic [1:0]                      req_size,
  output logic                            req_unsigned,
  output logic                            misalign_err,
  output logic [DATA_WIDTH-1:0]           err_addr,
  output logic                            load_use_hazard,
  output logic                            agu_busy
);

  localparam int OFF_W      = $clog2(BE_WIDTH);
  localparam bit HAS_DOUBLE = (DATA_WIDTH == 64);

  logic                  mem_op;
  logic                  advance;
  logic                  accept;
  logic                  legal;
  logic [DATA_WIDTH-1:0] operand;
  logic [DATA_WIDTH-1:0] addr;
  logic [7:0]            be_full;
  acc_size_e             size;

  assign mem_op   = in_is_load | in_is_store;
  assign agu_busy = req_valid & ~req_ready;
  assign advance  = ~stall_pipeline & ~agu_busy & ~load_use_hazard;
  assign accept   = advance & in_valid & mem_op;
  assign size     = acc_size_e'(in_size);

  agu_fwd_unit #(
    .DATA_WIDTH     (DATA_WIDTH),
    .GPR_ADDR_WIDTH (GPR_ADDR_WIDTH),
    .FWD_DEPTH      (FWD_DEPTH)
  ) u_fwd (
    .clk             (agu_clk),
    .rst             (agu_rst),
    .advance         (advance),
    .in_valid        (in_valid),
    .in_mem_op       (mem_op),
    .in_is_load      (in_is_load),
    .in_rd           (in_rd),
    .in_reg_wr_en    (in_reg_wr_en),
    .rs1_addr        (rs1_addr),
    .rs1_data        (rs1_data),
    .fwd_data        (fwd_data),
    .operand         (operand),
    .load_use_hazard (load_use_hazard)
  );

  assign addr    = operand + imm_val;
  assign be_full = be_gen(size, 3'(addr[OFF_W-1:0]));

  // Doubles only exist on the 64-bit datapath; a load+store combo is malformed.
  assign legal = is_aligned(size, addr[2:0])
               & ~((size == SZ_D) & ~HAS_DOUBLE)
               & ~(in_is_load & in_is_store);

  always_ff @(posedge agu_clk) begin
    if (agu_rst) begin
      req_valid    <= 1'b0;
      req_addr     <= '0;
      req_we       <= 1'b0;
      req_be       <= '0;
      req_size     <= 2'b00;
      req_unsigned <= 1'b0;
      misalign_err <= 1'b0;
      err_addr     <= '0;
    end else begin
      misalign_err <= accept & ~legal;
      if (accept & ~legal) err_addr <= addr;

      if (accept & legal) begin
        req_valid    <= 1'b1;
        req_addr     <= addr;
        req_we       <= in_is_store;
        req_be       <= be_full[BE_WIDTH-1:0];
        req_size     <= in_size;
        req_unsigned <= in_unsigned;
      end else if (req_ready) begin
        req_valid    <= 1'b0;
      end
    end
  end

endmodule
